blink_tick_gen: RTL and testbench

BLINK_TICK_GEN -- requirements
Module: blink_tick_gen

---
 rtl/blink_tick_gen.sv | 149 ++++++++++++++
 tb/tb_blink_tick_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_tick_gen.sv
// rtl/blink_tick_gen.sv - debounced push-button stepping a four-rate tick and LED blinker

// Two-flop synchronizer and level debouncer.
// fall_o pulses for one cycle, on the edge after the debounced level drops from 1 to 0.
module blink_tick_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic fall_o
);
  // The level is adopted on the edge whose mismatch count reaches this value.
  localparam logic [20:0] LAST = 21'(CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic [20:0] cnt_q, cnt_d;
  logic        fall_q, fall_d;

  // Next-state: count consecutive mismatching samples, adopt the new level after CYCLES of them
  always_comb begin
    sync1_d  = key_n_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 21'd1;
      end
    end
  end

  // State register; the idle (released) level is 1 everywhere after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// Rate-selectable tick generator.
// Each debounced press advances MODE and restarts the period; LED toggles after every TICK.
module blink_tick_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PERIOD0         = 50000000,
  parameter int PERIOD1         = 90000000,
  parameter int PERIOD2         = 25000000,
  parameter int PERIOD3         = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_N,
  output logic       TICK,
  output logic       LED,
  output logic [1:0] MODE,
  output logic       PRESS
);
  // Terminal count value for each mode.
  localparam logic [26:0] LAST0 = 27'(PERIOD0 - 1);
  localparam logic [26:0] LAST1 = 27'(PERIOD1 - 1);
  localparam logic [26:0] LAST2 = 27'(PERIOD2 - 1);
  localparam logic [26:0] LAST3 = 27'(PERIOD3 - 1);

  logic        fall;
  logic        press_q, press_d;
  logic [1:0]  mode_q, mode_d;
  logic [26:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic        led_q, led_d;

  blink_tick_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (CLOCK_50),
    .rst_i   (RESET),
    .key_n_i (KEY_N),
    .fall_o  (fall)
  );

  function automatic logic [26:0] last_of(input logic [1:0] m);
    logic [26:0] r;
    case (m)
      2'd0:    r = LAST0;
      2'd1:    r = LAST1;
      2'd2:    r = LAST2;
      default: r = LAST3;
    endcase
    return r;
  endfunction

  // Next-state: a press restarts the period in the next mode.
  // TICK is precomputed from the next count so it can come straight from a flop;
  // a press landing on the terminal count masks that tick.
  always_comb begin
    press_d = fall;
    mode_d  = mode_q;
    cnt_d   = cnt_q + 27'd1;
    if (press_q) begin
      mode_d = mode_q + 2'd1;
      cnt_d  = '0;
    end else if (cnt_q == last_of(mode_q)) begin
      cnt_d = '0;
    end
    tick_d = ~press_d & (cnt_d == last_of(mode_d));
    led_d  = led_q ^ tick_q;
  end

  // State register; reset clears every partial count and output
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      press_q <= 1'b0;
      mode_q  <= 2'd0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
    end
  end

  assign TICK  = tick_q;
  assign LED   = led_q;
  assign MODE  = mode_q;
  assign PRESS = press_q;

endmodule

// File: tb/tb_blink_tick_gen.sv
// tb/tb_blink_tick_gen.sv - directed and randomized check of blink_tick_gen against a behavioural model
`timescale 1ns/1ps
module tb_blink_tick_gen;
  localparam int D  = 4;
  localparam int P0 = 5;
  localparam int P1 = 9;
  localparam int P2 = 3;
  localparam int P3 = 2;

  int per [4] = '{P0, P1, P2, P3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic       tick, led, press;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  blink_tick_gen #(
    .DEBOUNCE_CYCLES (D),
    .PERIOD0         (P0),
    .PERIOD1         (P1),
    .PERIOD2         (P2),
    .PERIOD3         (P3)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .KEY_N    (key_n),
    .TICK     (tick),
    .LED      (led),
    .MODE     (mode),
    .PRESS    (press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the debounced level flips once the last D synchronized samples
  // all disagree with it; the tick position is the age since the last restart modulo the period.
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_stable = 1'b1;
  logic m_fall = 1'b0, m_press = 1'b0, m_tick = 1'b0, m_led = 1'b0;
  int   m_mode = 0, m_age = 0;
  logic m_win[$];
  logic smp, nfall, npress, ntick, nled;
  int   nmode, nage;
  bit   allmis;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1;
      m_fall = 1'b0; m_press = 1'b0; m_tick = 1'b0; m_led = 1'b0;
      m_mode = 0; m_age = 0;
      m_win.delete();
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = key_n;
      m_win.push_back(smp);
      if (m_win.size() > D) void'(m_win.pop_front());
      allmis = (m_win.size() == D);
      foreach (m_win[i]) if (m_win[i] == m_stable) allmis = 1'b0;
      nfall = 1'b0;
      if (allmis) begin
        m_stable = ~m_stable;
        nfall    = ~m_stable;
      end
      npress = m_fall;
      nmode  = m_press ? (m_mode + 1) % 4 : m_mode;
      nage   = m_press ? 0 : m_age + 1;
      ntick  = !npress && ((nage % per[nmode]) == per[nmode] - 1);
      nled   = m_led ^ m_tick;
      m_fall = nfall; m_press = npress; m_mode = nmode;
      m_age  = nage;  m_tick  = ntick;  m_led  = nled;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tick",  int'(tick),  int'(m_tick));
      check("model_led",   int'(led),   int'(m_led));
      check("model_mode",  int'(mode),  m_mode);
      check("model_press", int'(press), int'(m_press));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    key_n = 1'b1;
    step(2);
    rst   = 1'b0;
  endtask

  // Hold the key low until MODE reaches want; returns edges taken, then releases the key.
  task automatic press_key(input int want, output int lat);
    int n;
    n     = 0;
    key_n = 1'b0;
    do begin
      step(1);
      n++;
    end while (int'(mode) != want && n < 20);
    key_n = 1'b1;
    lat   = n;
  endtask

  task automatic wait_tick(output int n);
    int c;
    c = 0;
    do begin
      step(1);
      c++;
    end while (!tick && c < 30);
    n = c;
  endtask

  int exp_mode  [4] = '{1, 2, 3, 0};
  int exp_first [4] = '{8, 2, 1, 4};
  int exp_space [4] = '{9, 3, 2, 5};

  initial begin
    int lat, n, npr, len;
    logic v;

    // Reset held: outputs pinned regardless of KEY_N
    step(1);
    chk_en = 1'b1;
    key_n  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("hold_tick",  int'(tick),  0);
      check("hold_led",   int'(led),   0);
      check("hold_mode",  int'(mode),  0);
      check("hold_press", int'(press), 0);
    end

    // Free run; k counts negedges after the release point, the release cycle being cycle 1
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("free_tick", int'(tick), (k % 5 == 4) ? 1 : 0);
      check("free_mode", int'(mode), 0);
      if (k == 4)  check("free_led4",  int'(led), 0);
      if (k == 5)  check("free_led5",  int'(led), 1);
      if (k == 10) check("free_led10", int'(led), 0);
    end

    // Clean press timed so PRESS lands on the mode-0 terminal count
    do_reset();
    npr = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      npr += int'(press);
      if (k == 4)  check("col_tick4",   int'(tick),  1);
      if (k == 9)  check("col_press9",  int'(press), 1);
      if (k == 9)  check("col_tick9",   int'(tick),  0);
      if (k == 10) check("col_mode10",  int'(mode),  1);
      if (k == 10) check("col_led10",   int'(led),   1);
      if (k == 17) check("col_tick17",  int'(tick),  0);
      if (k == 18) check("col_tick18",  int'(tick),  1);
      if (k == 19) check("col_led19",   int'(led),   0);
      if (k == 27) check("col_tick27",  int'(tick),  1);
      if (k == 40) check("col_mode40",  int'(mode),  1);
      if (k == 2)  key_n = 1'b0;
      if (k == 22) key_n = 1'b1;
    end
    check("col_press_count", npr, 1);

    // Bounce: low 3, high 1, low 2, then high
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key_n = !(i < 3 || i == 4 || i == 5);
      step(1);
      check("bnc_press", int'(press), 0);
      check("bnc_mode",  int'(mode),  0);
      check("bnc_tick",  int'(tick),  ((i + 1) % 5 == 4) ? 1 : 0);
    end

    // Wrap through all four modes, measuring latency and tick cadence
    do_reset();
    for (int p = 0; p < 4; p++) begin
      press_key(exp_mode[p], lat);
      check("wrap_mode",    int'(mode), exp_mode[p]);
      check("wrap_latency", lat, D + 4);
      wait_tick(n);
      check("wrap_first_tick", n, exp_first[p]);
      wait_tick(n);
      check("wrap_spacing", n, exp_space[p]);
      step(10);
    end

    // Reset mid-operation: MODE=2, count=1, debounce count=2 when RESET is sampled
    do_reset();
    press_key(1, lat);
    step(10);
    press_key(2, lat);
    step(10);
    n = 0;
    while (!(m_mode == 2 && (m_age % 3) == 0) && n < 10) begin
      step(1);
      n++;
    end
    key_n = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst   = 1'b0;
    key_n = 1'b1;
    check("mid_rst_tick",  int'(tick),  0);
    check("mid_rst_led",   int'(led),   0);
    check("mid_rst_mode",  int'(mode),  0);
    check("mid_rst_press", int'(press), 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k <= 5) check("mid_tick", int'(tick), (k == 4) ? 1 : 0);
      check("mid_mode", int'(mode), 0);
    end

    // Randomized key runs with occasional resets, checked by the model every cycle
    do_reset();
    for (int c = 0; c < 3000; ) begin
      len = $urandom_range(1, 10);
      v   = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        key_n = v;
        rst   = ($urandom_range(0, 399) == 0);
        step(1);
        c++;
      end
    end
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
